bmp_pixel_writer: RTL and testbench

Receive end of the image pipeline. Accepts the processed 24-bit BGR pixel stream, one pixel per handshake. Packs the pixels little-endian into 32-bit words in BMP row layout, with each row zero-padded to a 4-byte boundary. Writes the words to the word memory that is later dumped as the output bitmap. Mirror of the bitmap-to-pixel stream feeding the pipeline.

---
 rtl/bmp_writer_pkg.sv | 26 ++
 rtl/bmp_byte_packer.sv | 50 +++++
 rtl/bmp_pixel_writer.sv | 156 +++++++++++++++
 tb/tb_bmp_pixel_writer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_writer_pkg.sv
// rtl/bmp_writer_pkg.sv - shared types, sizes and row-length helper for the BMP pixel writer
package bmp_writer_pkg;

  localparam int PIXEL_W         = 24;
  localparam int WORD_W          = 32;
  localparam int DIM_W           = 12;
  localparam int ADDR_W          = 20;
  localparam int BYTES_PER_PIXEL = 3;
  localparam int BYTES_PER_WORD  = 4;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ACTIVE,
    FLUSH,
    DONE
  } state_t;

  // Words per padded BMP row: ceil(3*width/4).
  function automatic logic [ADDR_W-1:0] row_words(input logic [DIM_W-1:0] w);
    logic [ADDR_W-1:0] wx;
    wx = ADDR_W'(w);
    return (wx * ADDR_W'(BYTES_PER_PIXEL) + ADDR_W'(BYTES_PER_WORD - 1)) >> 2;
  endfunction

endpackage

// File: rtl/bmp_byte_packer.sv
// rtl/bmp_byte_packer.sv - packs 3-byte pixels into little-endian 32-bit words with a flush for row padding
import bmp_writer_pkg::*;

module bmp_byte_packer (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               flush,
  input  logic [PIXEL_W-1:0] pix,
  output logic               word_valid,
  output logic [WORD_W-1:0]  word,
  output logic [1:0]         level
);

  logic [47:0] acc;
  logic [47:0] merged;

  // Bytes above 'level' in acc are always zero, so an OR appends the new pixel.
  always_comb begin
    merged = acc | ({24'b0, pix} << {level, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      level      <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (flush) begin
        word       <= acc[WORD_W-1:0];
        word_valid <= 1'b1;
        acc        <= '0;
        level      <= '0;
      end else if (push) begin
        if (level != 2'd0) begin
          word       <= merged[WORD_W-1:0];
          word_valid <= 1'b1;
          acc        <= {32'b0, merged[47:32]};
          level      <= level - 2'd1;
        end else begin
          acc   <= merged;
          level <= 2'd3;
        end
      end
    end
  end

endmodule

// File: rtl/bmp_pixel_writer.sv
// rtl/bmp_pixel_writer.sv - BGR pixel stream to padded BMP word memory writer; BMP_BOTTOM_UP_EN stores rows bottom-up
import bmp_writer_pkg::*;

module bmp_pixel_writer (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [DIM_W-1:0]   width,
  input  logic [DIM_W-1:0]   height,
  input  logic               pix_valid,
  output logic               pix_ready,
  input  logic [PIXEL_W-1:0] pix_data,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WORD_W-1:0]  mem_wdata,
  output logic               busy,
  output logic               done
);

  state_t            state, state_nxt;
  logic [DIM_W-1:0]  w_q, h_q, col, row;
  logic [ADDR_W-1:0] addr_ptr, next_base;
  logic [1:0]        level;
  logic              xfer, col_last, row_last, residual;
  logic              flush, gen_word, row_done;

  assign col_last = (col == w_q - DIM_W'(1));
  assign row_last = (row == h_q - DIM_W'(1));
  // After a row-end push the packer keeps bytes unless it held exactly one.
  assign residual = (level != 2'd1);

`ifdef BMP_BOTTOM_UP_EN
  logic [ADDR_W-1:0] row_base, rw;
  logic              calc_last;
  assign rw        = row_words(w_q);
  assign calc_last = (row == h_q - DIM_W'(2));
  assign next_base = row_base - rw;
`else
  assign next_base = addr_ptr + ADDR_W'(1);
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pix_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (width == '0 || height == '0)
            state_nxt = DONE;
`ifdef BMP_BOTTOM_UP_EN
          else if (height == DIM_W'(1))
            state_nxt = ACTIVE;
          else
            state_nxt = CALC;
`else
          else
            state_nxt = ACTIVE;
`endif
        end
      end
      CALC: begin
`ifdef BMP_BOTTOM_UP_EN
        if (calc_last) state_nxt = ACTIVE;
`else
        state_nxt = IDLE;
`endif
      end
      ACTIVE: begin
        pix_ready = 1'b1;
        if (pix_valid && col_last) begin
          if (residual)      state_nxt = FLUSH;
          else if (row_last) state_nxt = DONE;
        end
      end
      FLUSH: begin
        flush     = 1'b1;
        state_nxt = row_last ? DONE : ACTIVE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer     = pix_valid && pix_ready;
  assign gen_word = (xfer && level != 2'd0) || flush;
  assign row_done = (xfer && col_last && !residual) || flush;

  // mem_addr is registered alongside the packer's word so both land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_q      <= '0;
      h_q      <= '0;
      col      <= '0;
      row      <= '0;
      addr_ptr <= '0;
      mem_addr <= '0;
`ifdef BMP_BOTTOM_UP_EN
      row_base <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        w_q      <= width;
        h_q      <= height;
        col      <= '0;
        row      <= '0;
        addr_ptr <= '0;
`ifdef BMP_BOTTOM_UP_EN
        row_base <= '0;
`endif
      end
`ifdef BMP_BOTTOM_UP_EN
      if (state == CALC) begin
        row_base <= row_base + rw;
        addr_ptr <= addr_ptr + rw;
        row      <= calc_last ? '0 : row + DIM_W'(1);
      end
`endif
      if (xfer)
        col <= col_last ? '0 : col + DIM_W'(1);
      if (gen_word) begin
        mem_addr <= addr_ptr;
        addr_ptr <= row_done ? next_base : addr_ptr + ADDR_W'(1);
      end
      if (row_done) begin
        row <= row_last ? '0 : row + DIM_W'(1);
`ifdef BMP_BOTTOM_UP_EN
        row_base <= next_base;
`endif
      end
    end
  end

  bmp_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .push       (xfer),
    .flush      (flush),
    .pix        (pix_data),
    .word_valid (mem_we),
    .word       (mem_wdata),
    .level      (level)
  );

endmodule

// File: tb/tb_bmp_pixel_writer.sv
// tb/tb_bmp_pixel_writer.sv - scoreboard bench for bmp_pixel_writer; honours BMP_BOTTOM_UP_EN
module tb_bmp_pixel_writer;

  logic        clk = 1'b0;
  logic        reset, start, pix_valid, pix_ready, mem_we, busy, done;
  logic [11:0] width, height;
  logic [23:0] pix_data;
  logic [19:0] mem_addr;
  logic [31:0] mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [19:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] pix_q[$];
  exp_t        mon_e;

  always #5 clk = ~clk;

  bmp_pixel_writer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .width     (width),
    .height    (height),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && mem_we) begin
      check("we_while_busy", {63'b0, busy}, 64'd1);
      check("write_expected", {63'b0, exp_q.size() != 0}, 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", {44'b0, mem_addr}, {44'b0, mon_e.addr});
        check("wr_data", {32'b0, mem_wdata}, {32'b0, mon_e.data});
      end
    end
  end

  // Reference image: per row, serialise pixels as B,G,R bytes, zero-pad to 4, cut into words.
  task automatic model_frame(input int w, input int h);
    logic [7:0]  b[$];
    logic [23:0] p;
    exp_t        e;
    int          rw, base;
    rw = (3 * w + 3) / 4;
    for (int r = 0; r < h; r++) begin
      b.delete();
      for (int c = 0; c < w; c++) begin
        p = pix_q[r * w + c];
        b.push_back(p[7:0]);
        b.push_back(p[15:8]);
        b.push_back(p[23:16]);
      end
      while (b.size() % 4 != 0) b.push_back(8'h00);
`ifdef BMP_BOTTOM_UP_EN
      base = (h - 1 - r) * rw;
`else
      base = r * rw;
`endif
      for (int i = 0; i < b.size() / 4; i++) begin
        e.addr = 20'(base + i);
        e.data = {b[4*i+3], b[4*i+2], b[4*i+1], b[4*i]};
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic send_pix(input logic [23:0] p, input bit rnd);
    int g;
    if (rnd) begin
      pix_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    pix_valid = 1'b1;
    pix_data  = p;
    g = 0;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      g++;
      if (g > 50) begin
        check("ready_timeout", 64'd0, 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_pix_ready", {63'b0, pix_ready}, 64'd0);
    check("rst_mem_we",    {63'b0, mem_we},    64'd0);
    check("rst_mem_addr",  {44'b0, mem_addr},  64'd0);
    check("rst_mem_wdata", {32'b0, mem_wdata}, 64'd0);
    check("rst_busy",      {63'b0, busy},      64'd0);
    check("rst_done",      {63'b0, done},      64'd0);
  endtask

  task automatic run_frame(input int w, input int h, input bit rnd, input bit hold_start);
    int g;
    model_frame(w, h);
    width  = 12'(w);
    height = 12'(h);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("busy_after_start", {63'b0, busy}, 64'd1);
    if (hold_start) begin
      start  = 1'b1;
      width  = 12'd7;
      height = 12'd7;
    end
`ifdef BMP_BOTTOM_UP_EN
    if (w > 0 && h > 1) begin
      for (int c = 0; c < h - 1; c++) begin
        @(negedge clk);
        check("calc_ready", {63'b0, pix_ready}, 64'd0);
        check("calc_busy",  {63'b0, busy},      64'd1);
      end
    end
`endif
    if (w > 0 && h > 0) begin
      for (int i = 0; i < w * h; i++) begin
        send_pix(pix_q[i], rnd);
        if (i == w * h - 1) start = 1'b0;
        if ((i % w) == w - 1 && (3 * w) % 4 != 0) begin
          @(negedge clk);
          check("flush_ready", {63'b0, pix_ready}, 64'd0);
        end
      end
    end
    start = 1'b0;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!done && g < 100);
    check("done_seen",    {63'b0, done}, 64'd1);
    check("done_latency", 64'(g), 64'd1);
    @(posedge clk);
    #1;
    check("done_one_cycle", {63'b0, done}, 64'd0);
    check("idle_not_busy",  {63'b0, busy}, 64'd0);
    check("queue_drained",  64'(exp_q.size()), 64'd0);
    exp_q.delete();
    pix_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; width = '0; height = '0;
    pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    reset = 1'b0;
    @(posedge clk);
    #1;

    pix_q = '{24'h112233};
    run_frame(1, 1, 1'b0, 1'b0);

    pix_q = '{24'hA1A2A3, 24'hB1B2B3, 24'hC1C2C3, 24'hD1D2D3};
    run_frame(4, 1, 1'b0, 1'b0);

    pix_q = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
    run_frame(2, 2, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) pix_q.push_back(24'($urandom));
    run_frame(3, 3, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) pix_q.push_back(24'h300000 + 24'(i * 24'h010101));
    run_frame(3, 3, 1'b1, 1'b0);

    run_frame(0, 3, 1'b0, 1'b0);
    run_frame(3, 0, 1'b0, 1'b0);

    pix_q = '{24'h5A5B5C, 24'h6A6B6C};
    run_frame(2, 1, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) pix_q.push_back(24'($urandom));
    run_frame(5, 2, 1'b1, 1'b0);

    // Abort a 4x2 frame after five pixels, then start a fresh frame.
    for (int i = 0; i < 8; i++) pix_q.push_back(24'hE0E0E0 + 24'(i));
    model_frame(4, 2);
    width = 12'd4; height = 12'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_pix(pix_q[i], 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs();
    check("pre_reset_remaining", 64'(exp_q.size()), 64'd3);
    exp_q.delete();
    pix_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    pix_q = '{24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678};
    run_frame(4, 1, 1'b0, 1'b0);

    pix_q = '{24'h0F0E0D, 24'h1F1E1D, 24'h2F2E2D, 24'h3F3E3D, 24'h4F4E4D, 24'h5F5E5D};
    run_frame(2, 3, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
